// File: rtl/bcp_unit.sv
// Boolean constraint propagation engine: walks the occurrence list of a newly
// assigned variable, pushes forced implications and flags the first conflicting clause.
module bcp_unit #(
  parameter int VAR_W = 9,
  parameter int CL_W  = 10,
  parameter int LITS  = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [VAR_W-1:0]      prop_var,
  output logic                  occ_rd_en,
  output logic [VAR_W-1:0]      occ_addr,
  input  logic [CL_W-1:0]       occ_first,
  input  logic [CL_W-1:0]       occ_last,
  output logic                  cl_rd_en,
  output logic [CL_W-1:0]       cl_addr,
  input  logic [LITS*VAR_W-1:0] cl_lit_var,
  input  logic [LITS-1:0]       cl_lit_neg,
  output logic [LITS*VAR_W-1:0] vs_var,
  input  logic [LITS-1:0]       vs_assigned,
  input  logic [LITS-1:0]       vs_val,
  output logic                  imp_push,
  output logic [VAR_W-1:0]      imp_var,
  output logic                  imp_val,
  output logic                  imp_type,
  input  logic                  imp_full,
  output logic                  busy,
  output logic                  done,
  output logic                  conflict,
  output logic [CL_W-1:0]       conflict_clause
);

  localparam int CNT_W = $clog2(LITS + 1);

  typedef enum logic [2:0] {IDLE, OCC_WAIT, CL_WAIT, EVAL, DONE} state_t;

  state_t            state_reg, state_next;
  logic [VAR_W-1:0]  var_reg, var_next;
  logic [CL_W-1:0]   last_reg, last_next;
  logic [CL_W-1:0]   idx_reg, idx_next;
  logic              conflict_reg, conflict_next;
  logic [CL_W-1:0]   conflict_clause_reg, conflict_clause_next;
  logic              occ_rd_en_reg, occ_rd_en_next;
  logic              cl_rd_en_reg, cl_rd_en_next;

  logic [LITS-1:0]   lit_true;
  logic [LITS-1:0]   lit_unas;
  logic [CNT_W-1:0]  unas_cnt;
  logic [VAR_W-1:0]  unit_var;
  logic              unit_neg;
  logic              advance;

  // Clause memory holds its output, so EVAL classifies the literals straight off the read port.
  for (genvar gi = 0; gi < LITS; gi++) begin : g_slot
    logic active;
    assign active       = |cl_lit_var[gi*VAR_W +: VAR_W];
    assign lit_true[gi] = active & vs_assigned[gi] & (vs_val[gi] != cl_lit_neg[gi]);
    assign lit_unas[gi] = active & ~vs_assigned[gi];
  end

  // OR-merge is exact when only one slot is unassigned, the only case where it is used.
  always_comb begin
    unas_cnt = '0;
    unit_var = '0;
    unit_neg = 1'b0;
    for (int i = 0; i < LITS; i++) begin
      if (lit_unas[i]) begin
        unas_cnt = unas_cnt + CNT_W'(1);
        unit_var = unit_var | cl_lit_var[i*VAR_W +: VAR_W];
        unit_neg = unit_neg | cl_lit_neg[i];
      end
    end
  end

  always_comb begin
    state_next           = state_reg;
    var_next             = var_reg;
    last_next            = last_reg;
    idx_next             = idx_reg;
    conflict_next        = conflict_reg;
    conflict_clause_next = conflict_clause_reg;
    occ_rd_en_next       = 1'b0;
    cl_rd_en_next        = 1'b0;
    imp_push             = 1'b0;
    advance              = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          var_next             = prop_var;
          occ_rd_en_next       = 1'b1;
          conflict_next        = 1'b0;
          conflict_clause_next = '0;
          state_next           = OCC_WAIT;
        end
      end
      OCC_WAIT: begin
        // First cycle carries the read request; the range is valid on the second.
        if (!occ_rd_en_reg) begin
          last_next = occ_last;
          if (occ_first > occ_last) begin
            state_next = DONE;
          end else begin
            idx_next      = occ_first;
            cl_rd_en_next = 1'b1;
            state_next    = CL_WAIT;
          end
        end
      end
      CL_WAIT: state_next = EVAL;
      EVAL: begin
        if (|lit_true) begin
          advance = 1'b1;
        end else if (unas_cnt == CNT_W'(0)) begin
          conflict_next        = 1'b1;
          conflict_clause_next = idx_reg;
          state_next           = DONE;
        end else if (unas_cnt == CNT_W'(1)) begin
          if (!imp_full) begin
            imp_push = 1'b1;
            advance  = 1'b1;
          end
        end else begin
          advance = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    if (advance) begin
      if (idx_reg == last_reg) begin
        state_next = DONE;
      end else begin
        idx_next      = idx_reg + CL_W'(1);
        cl_rd_en_next = 1'b1;
        state_next    = CL_WAIT;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg           <= IDLE;
      var_reg             <= '0;
      last_reg            <= '0;
      idx_reg             <= '0;
      conflict_reg        <= 1'b0;
      conflict_clause_reg <= '0;
      occ_rd_en_reg       <= 1'b0;
      cl_rd_en_reg        <= 1'b0;
    end else begin
      state_reg           <= state_next;
      var_reg             <= var_next;
      last_reg            <= last_next;
      idx_reg             <= idx_next;
      conflict_reg        <= conflict_next;
      conflict_clause_reg <= conflict_clause_next;
      occ_rd_en_reg       <= occ_rd_en_next;
      cl_rd_en_reg        <= cl_rd_en_next;
    end
  end

  assign occ_rd_en       = occ_rd_en_reg;
  assign occ_addr        = var_reg;
  assign cl_rd_en        = cl_rd_en_reg;
  assign cl_addr         = idx_reg;
  assign vs_var          = cl_lit_var;
  assign imp_var         = unit_var;
  assign imp_val         = ~unit_neg;
  assign imp_type        = 1'b1;
  assign busy            = (state_reg != IDLE);
  assign done            = (state_reg == DONE);
  assign conflict        = conflict_reg;
  assign conflict_clause = conflict_clause_reg;

endmodule

// File: doc/bcp_unit.md
BCP_UNIT -- requirements
Module: bcp_unit

Interface
REQ-001 SHALL have parameter VAR_W, default 9: variable-ID width; ID 0 means unused literal slot.
REQ-002 SHALL have parameter CL_W, default 10: clause-index width.
REQ-003 SHALL have parameter LITS, default 3: literal slots per clause word.
REQ-004 clock  in  1  sole clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle pulse requesting BCP for prop_var; honoured only in IDLE.
REQ-007 prop_var  in  VAR_W  variable just assigned; sampled on accepted start.
REQ-008 occ_rd_en / occ_addr  out  1 / VAR_W  occurrence-table read request; occ_addr = latched variable.
REQ-009 occ_first / occ_last  in  CL_W each  inclusive clause-index range, valid the cycle after occ_rd_en.
REQ-010 cl_rd_en / cl_addr  out  1 / CL_W  clause-memory read request.
REQ-011 cl_lit_var / cl_lit_neg  in  LITS*VAR_W / LITS  literal IDs and negation bits, valid the cycle after cl_rd_en.
REQ-012 vs_var  out  LITS*VAR_W  combinational var-state read addresses = cl_lit_var.
REQ-013 vs_assigned / vs_val  in  LITS / LITS  same-cycle assigned flag and value per slot.
REQ-014 imp_push / imp_var / imp_val / imp_type  out  1 / VAR_W / 1 / 1  push to the implication stack.
REQ-015 imp_full  in  1  implication stack full.
REQ-016 busy  out  1  high from the cycle after an accepted start through the DONE cycle.
REQ-017 done  out  1  one-cycle completion pulse.
REQ-018 conflict / conflict_clause  out  1 / CL_W  conflict flag and clause index; held until the next accepted start.

Function
REQ-019 Literal truth: slot active iff var != 0; true iff vs_assigned and vs_val != neg; false iff vs_assigned and vs_val == neg; otherwise unassigned.
REQ-020 FSM states: IDLE, OCC_WAIT, CL_WAIT, EVAL, DONE.
REQ-021 IDLE + start: latch prop_var; pulse occ_rd_en; clear conflict; go OCC_WAIT. start in any other state is ignored.
REQ-022 OCC_WAIT: latch occ_first/occ_last. If occ_first > occ_last (unsigned), go DONE. Else set idx = occ_first, pulse cl_rd_en with cl_addr = idx, go CL_WAIT.
REQ-023 CL_WAIT: clause data arrives; go EVAL. Data is captured into a register, or EVAL reads it directly if clause memory holds its output.
REQ-024 EVAL, any active literal true: clause satisfied; advance.
REQ-025 EVAL, no true literal and zero unassigned active literals: set conflict = 1, conflict_clause = idx; go DONE. The remaining range is abandoned.
REQ-026 EVAL, no true literal and exactly one unassigned active literal: if imp_full = 0, pulse imp_push with imp_var = that literal's ID, imp_val = ~neg, imp_type = 1 (forced), then advance. If imp_full = 1, stay in EVAL with imp_push = 0 and re-evaluate each cycle.
REQ-027 EVAL, no true literal and two or more unassigned literals: advance with no push.
REQ-028 Advance: if idx == occ_last, go DONE. Else idx = idx + 1, pulse cl_rd_en, go CL_WAIT. idx never wraps; the comparison is equality on the latched occ_last.
REQ-029 A clause with all slots unused (every var 0) evaluates as conflict; this is legal behaviour and is not filtered.
REQ-030 DONE: done = 1 for exactly one cycle; next state IDLE.
REQ-031 At most one imp_push per clause and one per cycle. Duplicate or contradictory implications are not filtered.
REQ-032 Latency per evaluated clause without stall: 2 cycles. Total = 2 + 2*N + 1 cycles from start to done.
REQ-033 occ_rd_en, cl_rd_en, imp_push and done are single-cycle pulses and are never asserted in IDLE.

Reset
REQ-034 reset low SHALL immediately force IDLE and drive busy, done, conflict, imp_push, occ_rd_en and cl_rd_en to 0; conflict_clause, idx and latched data go to 0.
REQ-035 reset asserted mid-operation drops all in-progress evaluation and any stalled push; after release the block accepts a new start.

Verification
REQ-036 Empty list: occ_first = 5, occ_last = 4 -> done 3 cycles after start, no cl_rd_en, conflict = 0.
REQ-037 Unit clause: clause (x3, ~x7, x9) with x3 = 0, x7 = 1, x9 unassigned -> one imp_push with imp_var = 9, imp_val = 1, imp_type = 1.
REQ-038 Conflict mid-range: range 10..12, clause 11 all-false -> conflict = 1, conflict_clause = 11; clause 12 never read.
REQ-039 Full stack: imp_full held high 4 cycles during a unit clause -> imp_push asserted only once, in the cycle after imp_full drops.
REQ-040 Range 0..3 with all clauses satisfied -> 4 cl_rd_en pulses, done at cycle 11, no push.
REQ-041 reset pulsed low while in CL_WAIT -> busy = 0 immediately; a new start afterwards completes normally.
